// File: rtl/video_crop_writer_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
//   Shared types and defaults for the video capture write path.
//   - state_t    : capture FSM states
//   - VS_POL_DEF : default active level of vertical sync
//   - CNT_W_DEF  : default width of x/y counters and crop window registers
// ---------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        S_SYNC,     // waiting for the first vs edge, no writes
        S_FRAME,    // capture active
        S_DROP      // FIFO rejected a write; discard rest of frame
    } state_t;

    localparam logic        VS_POL_DEF = 1'b1;
    localparam int unsigned CNT_W_DEF  = 12;

endpackage : video_pkg

// File: rtl/video_crop_writer_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
//   Single-cycle transition detector. Compares the live input against a
//   1-cycle delayed copy and pulses when the input has just moved into the
//   level POL (POL=1: rising edge, POL=0: falling edge).
//
//   clk   in  : sampling clock
//   rst   in  : asynchronous, active-high reset (delayed copy -> 0)
//   d     in  : signal to watch
//   pulse out : high for the cycle in which d first shows level POL
// ---------------------------------------------------------------------------
module edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = (d == POL) && (d_q != POL);

endmodule : edge_det

// File: rtl/video_crop_writer.sv
// ---------------------------------------------------------------------------
// video_crop_writer
//   Write-side capture stage for the line-buffer async FIFO. Counts pixel
//   positions in the wr_clk domain, crops each frame to a window latched at
//   the vs edge and issues one FIFO write per window pixel (1-cycle latency).
//   Tags the first write of a frame (sof) and the last write of each cropped
//   line (eol). A write that hits a full FIFO sets a sticky overflow flag and
//   the rest of that frame is dropped so the read side never sees a torn frame.
//
//   wr_clk     in  : pixel clock / FIFO write clock
//   rst        in  : asynchronous, active-high reset
//   vs_in      in  : vertical sync, active level VS_POL
//   de_in      in  : data enable for active pixels
//   pix_in     in  : pixel data, valid with de_in
//   crop_x/y   in  : window origin (pixels / lines)
//   crop_w/h   in  : window size, 0 = no output
//   ovf_clr    in  : clears sticky overflow
//   fifo_full  in  : FIFO full flag
//   fifo_wr_en out : FIFO write strobe
//   fifo_din   out : FIFO write data, holds when no write
//   sof        out : first write of a frame
//   eol        out : last write of a cropped line
//   overflow   out : sticky, a write was rejected by a full FIFO
//   frame_cnt  out : frames started since reset (wraps)
// ---------------------------------------------------------------------------
module video_crop_writer
    import video_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter logic        VS_POL = VS_POL_DEF
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [DATA_W-1:0] pix_in,
    input  logic [CNT_W-1:0]  crop_x,
    input  logic [CNT_W-1:0]  crop_y,
    input  logic [CNT_W-1:0]  crop_w,
    input  logic [CNT_W-1:0]  crop_h,
    input  logic              ovf_clr,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              sof,
    output logic              eol,
    output logic              overflow,
    output logic [7:0]        frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   WIDE_ONE = {{CNT_W{1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // Sync / enable edges
    // -----------------------------------------------------------------------
    logic vs_edge;
    logic de_fall;

    edge_det #(.POL(VS_POL)) u_vs_edge (
        .clk   (wr_clk),
        .rst   (rst),
        .d     (vs_in),
        .pulse (vs_edge)
    );

    edge_det #(.POL(1'b0)) u_de_fall (
        .clk   (wr_clk),
        .rst   (rst),
        .d     (de_in),
        .pulse (de_fall)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state;
    logic             first_done;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] sh_x;
    logic [CNT_W-1:0] sh_y;
    logic [CNT_W-1:0] sh_w;
    logic [CNT_W-1:0] sh_h;

    // -----------------------------------------------------------------------
    // Current-pixel view. On a vs edge the pixel in the same cycle already
    // belongs to the new frame: position (0,0) against the incoming window.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cur_x;
    logic [CNT_W-1:0] cur_y;
    logic [CNT_W-1:0] win_x;
    logic [CNT_W-1:0] win_y;
    logic [CNT_W-1:0] win_w;
    logic [CNT_W-1:0] win_h;
    logic [CNT_W:0]   px;
    logic [CNT_W:0]   py;
    logic [CNT_W:0]   x_lo;
    logic [CNT_W:0]   x_hi;
    logic [CNT_W:0]   y_lo;
    logic [CNT_W:0]   y_hi;
    logic             in_win;
    logic             at_eol;
    logic             reject;
    logic             capture;
    logic             do_wr;
    logic             is_first;

    always_comb begin
        cur_x = vs_edge ? '0     : x_cnt;
        cur_y = vs_edge ? '0     : y_cnt;
        win_x = vs_edge ? crop_x : sh_x;
        win_y = vs_edge ? crop_y : sh_y;
        win_w = vs_edge ? crop_w : sh_w;
        win_h = vs_edge ? crop_h : sh_h;

        // One extra bit so origin+size never wraps; windows running past
        // the line/frame are clipped simply because x/y never get there.
        px   = {1'b0, cur_x};
        py   = {1'b0, cur_y};
        x_lo = {1'b0, win_x};
        x_hi = {1'b0, win_x} + {1'b0, win_w};
        y_lo = {1'b0, win_y};
        y_hi = {1'b0, win_y} + {1'b0, win_h};

        in_win = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
        at_eol = (px + WIDE_ONE) == x_hi;

        // The FIFO drops a strobe it sees while full.
        reject   = fifo_wr_en && fifo_full;
        // A vs edge restarts capture even in the cycle of a rejection.
        capture  = vs_edge || ((state == S_FRAME) && !reject);
        do_wr    = capture && de_in && in_win;
        is_first = vs_edge || !first_done;
    end

    // -----------------------------------------------------------------------
    // Position counters
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vs_edge) begin
            // A pixel coinciding with the vs edge consumes x=0.
            x_cnt <= de_in ? CNT_ONE : '0;
            y_cnt <= '0;
        end else if (de_in) begin
            // Saturate so an over-long line cannot wrap back into the window.
            if (!(&x_cnt)) begin
                x_cnt <= x_cnt + CNT_ONE;
            end
        end else if (de_fall) begin
            x_cnt <= '0;
            if (!(&y_cnt)) begin
                y_cnt <= y_cnt + CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Crop window shadow, frozen for the whole frame
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            sh_x <= '0;
            sh_y <= '0;
            sh_w <= '0;
            sh_h <= '0;
        end else if (vs_edge) begin
            sh_x <= crop_x;
            sh_y <= crop_y;
            sh_w <= crop_w;
            sh_h <= crop_h;
        end
    end

    // -----------------------------------------------------------------------
    // FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state      <= S_SYNC;
            first_done <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (vs_edge) begin
                state <= S_FRAME;
            end else if ((state == S_FRAME) && reject) begin
                state <= S_DROP;
            end

            fifo_wr_en <= do_wr;
            sof        <= do_wr && is_first;
            eol        <= do_wr && at_eol;
            if (do_wr) begin
                fifo_din <= pix_in;
            end

            if (vs_edge) begin
                first_done <= do_wr;
            end else if (do_wr) begin
                first_done <= 1'b1;
            end

            // A rejection in the same cycle as the clear keeps the flag set.
            if (reject) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (vs_edge) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule : video_crop_writer
